mux_scan_n_1: RTL and testbench

Parametrised, registered N:1 channel selector with manual and auto-scan modes. Each accepted sample is tagged with its source channel and presented through a valid/ready output register. It is the successor to the combinational 4:1 decoder/tri-state mux: it adds configurable channel count and width, a sequential channel pointer, a dwell counter and back-pressure. It sits between parallel sensor/data lanes and a single downstream consumer.

---
 rtl/mux_scan_n_1.sv | 79 +++++++
 tb/tb_mux_scan_n_1.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mux_scan_n_1.sv
// mux_scan_n_1: registered N:1 channel selector with manual and auto-scan modes and a valid/ready output.
// Define MUX_SCAN_TRISTATE_EN to add out_oe and tri-state out while no sample is valid.
module mux_scan_n_1 #(
  parameter int N_CH = 4,
  parameter int W = 1,
  parameter int DWELL = 1,
  localparam int SW = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH*W-1:0] in,
  input  logic [SW-1:0]   sel,
  input  logic            sel_load,
  input  logic            mode,
  input  logic            en,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [W-1:0]    out,
  output logic [SW-1:0]   out_ch,
  output logic            sel_err
`ifdef MUX_SCAN_TRISTATE_EN
  ,
  output logic            out_oe
`endif
);
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [SW-1:0] PTR_MAX = SW'(N_CH - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL - 1);
  localparam logic [SW:0] N_LIM = (SW + 1)'(N_CH);
  typedef enum logic {MAN, SCAN} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d, out_ch_q, out_ch_d, ptr_nxt;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [W-1:0] out_q, out_d;
  logic valid_q, valid_d, sel_err_q, sel_err_d, take, load_ok, adv, last;
  always_comb begin
    take = en & (~valid_q | out_ready);
    load_ok = sel_load & ({1'b0, sel} < N_LIM);
    state_d = mode ? SCAN : MAN;
    sel_err_d = sel_load & ~load_ok;
    out_d = take ? in[ptr_q*W +: W] : out_q;
    out_ch_d = take ? ptr_q : out_ch_q;
    valid_d = take | (valid_q & ~out_ready);
    adv = (state_q == SCAN) & take;
    last = dwell_q == DWELL_MAX;
    ptr_nxt = ptr_q == PTR_MAX ? '0 : ptr_q + 1'b1;
    // dwell stays cleared in MAN, so entering SCAN always starts a fresh dwell
    dwell_d = (load_ok | state_q == MAN) ? '0 : adv ? (last ? '0 : dwell_q + 1'b1) : dwell_q;
    ptr_d = load_ok ? sel : (adv & last) ? ptr_nxt : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MAN;
      ptr_q <= '0;
      dwell_q <= '0;
      out_q <= '0;
      out_ch_q <= '0;
      valid_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      dwell_q <= dwell_d;
      out_q <= out_d;
      out_ch_q <= out_ch_d;
      valid_q <= valid_d;
      sel_err_q <= sel_err_d;
    end
  end
  assign out_valid = valid_q;
  assign out_ch = out_ch_q;
  assign sel_err = sel_err_q;
`ifdef MUX_SCAN_TRISTATE_EN
  assign out_oe = valid_q;
  assign out = valid_q ? out_q : 'z;
`else
  assign out = valid_q ? out_q : '0;
`endif
endmodule

// File: tb/tb_mux_scan_n_1.sv
// tb_mux_scan_n_1: directed checks of mux_scan_n_1 with a 4-channel and a 3-channel instance.
module tb_mux_scan_n_1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] in4 = 4'b1110;
  logic [2:0] in3 = 3'b010;
  logic [1:0] sel = 2'd0;
  logic sel_load = 1'b0, mode = 1'b0, en = 1'b1, out_ready = 1'b1;
  logic v4, e4, v3, e3;
  logic [0:0] o4, o3;
  logic [1:0] c4, c3;
  int checks = 0, errors = 0;
`ifdef MUX_SCAN_TRISTATE_EN
  logic oe4, oe3;
`endif
  always #5 clk = ~clk;
  mux_scan_n_1 #(.N_CH(4), .W(1), .DWELL(2)) u4 (
    .clk(clk), .rst_n(rst_n), .in(in4), .sel(sel), .sel_load(sel_load), .mode(mode),
    .en(en), .out_ready(out_ready), .out_valid(v4), .out(o4), .out_ch(c4), .sel_err(e4)
`ifdef MUX_SCAN_TRISTATE_EN
    , .out_oe(oe4)
`endif
  );
  mux_scan_n_1 #(.N_CH(3), .W(1), .DWELL(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in(in3), .sel(sel), .sel_load(sel_load), .mode(mode),
    .en(en), .out_ready(out_ready), .out_valid(v3), .out(o3), .out_ch(c3), .sel_err(e3)
`ifdef MUX_SCAN_TRISTATE_EN
    , .out_oe(oe3)
`endif
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; in4 = 4'b1110;
    repeat (3) step;
    checks++; if ({v4, o4, c4, e4} !== 5'b0) begin errors++; $display("FAIL reset_hold got %b want 00000", {v4, o4, c4, e4}); end
    checks++; if ({v3, o3, c3, e3} !== 5'b0) begin errors++; $display("FAIL reset_hold3 got %b want 00000", {v3, o3, c3, e3}); end
    rst_n = 1'b1;
    step;
    checks++; if ({v4, o4, c4} !== 4'b1000) begin errors++; $display("FAIL reset_release got v/o/ch %b want 1000", {v4, o4, c4}); end
  endtask
  task automatic test_manual;
    logic [3:0] exp_o = 4'b1110;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); sel_load = 1'b1;
      step;
      sel_load = 1'b0;
      step;
      checks++; if (c4 !== 2'(s) || o4 !== exp_o[s] || v4 !== 1'b1) begin errors++; $display("FAIL manual_%0d got ch=%0d out=%b v=%b want ch=%0d out=%b v=1", s, c4, o4, v4, s, exp_o[s]); end
      checks++; if (e4 !== 1'b0) begin errors++; $display("FAIL manual_err_%0d got %b want 0", s, e4); end
    end
  endtask
  task automatic test_scan;
    logic [1:0] exp_ch [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic       exp_o  [10] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
    in4 = 4'b1010; en = 1'b0; mode = 1'b1; sel = 2'd0; sel_load = 1'b1;
    step;
    sel_load = 1'b0; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step;
      checks++; if (c4 !== exp_ch[i] || o4 !== exp_o[i] || v4 !== 1'b1) begin errors++; $display("FAIL scan_%0d got ch=%0d out=%b v=%b want ch=%0d out=%b v=1", i, c4, o4, v4, exp_ch[i], exp_o[i]); end
    end
  endtask
  task automatic test_back_pressure;
    logic [1:0] exp_ch [3] = '{1, 1, 2};
    logic       exp_o  [3] = '{1, 1, 0};
    out_ready = 1'b0; in4 = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step;
      checks++; if (c4 !== 2'd0 || o4 !== 1'b0 || v4 !== 1'b1) begin errors++; $display("FAIL stall_%0d got ch=%0d out=%b v=%b want ch=0 out=0 v=1", i, c4, o4, v4); end
    end
    out_ready = 1'b1; in4 = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++; if (c4 !== exp_ch[i] || o4 !== exp_o[i] || v4 !== 1'b1) begin errors++; $display("FAIL resume_%0d got ch=%0d out=%b want ch=%0d out=%b", i, c4, o4, exp_ch[i], exp_o[i]); end
    end
  endtask
  task automatic test_collision;
    rst_n = 1'b0; en = 1'b0; mode = 1'b1; sel_load = 1'b0; out_ready = 1'b1; in3 = 3'b010;
    step;
    rst_n = 1'b1;
    step;
    en = 1'b1;
    step;
    checks++; if (c3 !== 2'd0) begin errors++; $display("FAIL coll_first got ch=%0d want 0", c3); end
    sel = 2'd1; sel_load = 1'b1;
    step;
    checks++; if (c3 !== 2'd0) begin errors++; $display("FAIL coll_edge got ch=%0d want 0", c3); end
    sel_load = 1'b0;
    step;
    checks++; if (c3 !== 2'd1 || o3 !== 1'b1) begin errors++; $display("FAIL coll_next got ch=%0d out=%b want ch=1 out=1", c3, o3); end
    step;
    checks++; if (c3 !== 2'd1) begin errors++; $display("FAIL coll_dwell got ch=%0d want 1", c3); end
    sel = 2'd3; sel_load = 1'b1;
    step;
    checks++; if (e3 !== 1'b1 || c3 !== 2'd2) begin errors++; $display("FAIL bad_sel got err=%b ch=%0d want err=1 ch=2", e3, c3); end
    checks++; if (e4 !== 1'b0) begin errors++; $display("FAIL good_sel4 got err=%b want 0", e4); end
    sel_load = 1'b0;
    step;
    checks++; if (e3 !== 1'b0 || c3 !== 2'd2) begin errors++; $display("FAIL bad_sel_after got err=%b ch=%0d want err=0 ch=2", e3, c3); end
    step;
    checks++; if (c3 !== 2'd0 || o3 !== 1'b0) begin errors++; $display("FAIL wrap3 got ch=%0d out=%b want ch=0 out=0", c3, o3); end
  endtask
  task automatic test_output_driver;
    en = 1'b0; out_ready = 1'b1;
    step;
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", v3); end
`ifdef MUX_SCAN_TRISTATE_EN
    checks++; if (o3 !== 1'bz || oe3 !== 1'b0) begin errors++; $display("FAIL idle_drive got out=%b oe=%b want out=z oe=0", o3, oe3); end
`else
    checks++; if (o3 !== 1'b0) begin errors++; $display("FAIL idle_drive got out=%b want 0", o3); end
`endif
  endtask
  initial begin
    test_reset;
    test_manual;
    test_scan;
    test_back_pressure;
    test_collision;
    test_output_driver;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
